// File: rtl/mask_sequencer_pkg.sv
// Shared mode codes, state encodings and the state-to-mode mapping for the
// screen-mode sequencer feeding the draw-mask compositor.
package mask_sequencer_pkg;

    localparam logic [1:0] MODE_SELECT = 2'b01;
    localparam logic [1:0] MODE_GAME   = 2'b00;
    localparam logic [1:0] MODE_RESULT = 2'b10;

    typedef enum logic [2:0] {
        MS_SELECT    = 3'd0,
        MS_GAME_IN   = 3'd1,
        MS_GAME      = 3'd2,
        MS_RESULT_IN = 3'd3,
        MS_RESULT    = 3'd4
    } ms_state_e;

    // Fade-in states share the mode code of the state they lead into.
    function automatic logic [1:0] mode_of(ms_state_e s);
        case (s)
            MS_SELECT:               mode_of = MODE_SELECT;
            MS_GAME_IN, MS_GAME:     mode_of = MODE_GAME;
            MS_RESULT_IN, MS_RESULT: mode_of = MODE_RESULT;
            default:                 mode_of = MODE_SELECT;
        endcase
    endfunction

    function automatic logic is_fade(ms_state_e s);
        is_fade = (s == MS_GAME_IN) || (s == MS_RESULT_IN);
    endfunction

endpackage

// File: rtl/mask_sequencer_color_dim.sv
// Combinational per-channel dimmer: each 4-bit RGB channel is shifted right
// on its own, so no bits leak between channels.
module mask_sequencer_color_dim (
    input  logic [11:0] color_i,
    input  logic [1:0]  shift_i,
    output logic [11:0] color_o
);

    // Independent logical right shift of R, G and B.
    always_comb begin
        color_o = {color_i[11:8] >> shift_i,
                   color_i[7:4]  >> shift_i,
                   color_i[3:0]  >> shift_i};
    end

endmodule

// File: rtl/mask_sequencer.sv
// Frame-aligned screen-mode sequencer: select -> game -> result with dim
// fade ramps, plus the registered dimmed background colour.
module mask_sequencer
    import mask_sequencer_pkg::*;
#(
    parameter int FADE_FRAMES   = 8,
    parameter int RESULT_FRAMES = 180,
    parameter int DIM_MAX       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn_start,
    input  logic        game_over,
    input  logic [11:0] pri_color,
    output logic [1:0]  enable,
    output logic [11:0] dim_color,
    output logic [1:0]  dim_level,
    output logic        in_transition
);

    localparam int FADE_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam int HOLD_W = $clog2(RESULT_FRAMES + 1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESULT_FRAMES);
    localparam logic [1:0]        DIM_TOP   = 2'(DIM_MAX);

    ms_state_e         state_q, state_d;
    logic [FADE_W-1:0] fade_q, fade_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        dim_q, dim_d;
    logic              start_pend_q, start_pend_d;
    logic              over_pend_q, over_pend_d;
    logic [1:0]        enable_q;
    logic              in_trans_q;
    logic [11:0]       dim_color_q;
    logic [11:0]       dim_color_s;
    logic              start_eff_s, over_eff_s;

    mask_sequencer_color_dim u_color_dim (
        .color_i (pri_color),
        .shift_i (dim_q),
        .color_o (dim_color_s)
    );

    // Next-state logic; a pulse arriving on a tick cycle is seen by that tick.
    always_comb begin
        state_d      = state_q;
        fade_d       = fade_q;
        hold_d       = hold_q;
        dim_d        = dim_q;
        start_eff_s  = start_pend_q | btn_start;
        over_eff_s   = over_pend_q | game_over;
        start_pend_d = start_eff_s;
        over_pend_d  = over_eff_s;
        case (state_q)
            MS_SELECT: begin
                over_pend_d = 1'b0;
                if (frame_tick && start_eff_s) begin
                    state_d      = MS_GAME_IN;
                    start_pend_d = 1'b0;
                    fade_d       = {FADE_W{1'b0}};
                end else begin
                    dim_d = DIM_TOP;
                end
            end
            MS_GAME_IN: begin
                start_pend_d = 1'b0;
                if (frame_tick && (fade_q == FADE_LAST)) begin
                    fade_d = {FADE_W{1'b0}};
                    if (dim_q <= 2'd1) begin
                        dim_d   = 2'd0;
                        state_d = MS_GAME;
                    end else begin
                        dim_d = dim_q - 2'd1;
                    end
                end else if (frame_tick) begin
                    fade_d = fade_q + {{(FADE_W-1){1'b0}}, 1'b1};
                end else begin
                    fade_d = fade_q;
                end
            end
            MS_GAME: begin
                start_pend_d = 1'b0;
                dim_d        = 2'd0;
                if (frame_tick && over_eff_s) begin
                    state_d     = MS_RESULT_IN;
                    over_pend_d = 1'b0;
                    fade_d      = {FADE_W{1'b0}};
                end else begin
                    state_d = MS_GAME;
                end
            end
            MS_RESULT_IN: begin
                start_pend_d = 1'b0;
                if (frame_tick && (fade_q == FADE_LAST)) begin
                    fade_d = {FADE_W{1'b0}};
                    if (dim_q >= (DIM_TOP - 2'd1)) begin
                        dim_d   = DIM_TOP;
                        state_d = MS_RESULT;
                        hold_d  = HOLD_INIT;
                    end else begin
                        dim_d = dim_q + 2'd1;
                    end
                end else if (frame_tick) begin
                    fade_d = fade_q + {{(FADE_W-1){1'b0}}, 1'b1};
                end else begin
                    fade_d = fade_q;
                end
            end
            MS_RESULT: begin
                over_pend_d = 1'b0;
                dim_d       = DIM_TOP;
                if (frame_tick && (hold_q == {HOLD_W{1'b0}})) begin
                    if (start_eff_s) begin
                        state_d      = MS_SELECT;
                        start_pend_d = 1'b0;
                    end else begin
                        state_d = MS_RESULT;
                    end
                end else if (frame_tick) begin
                    hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d      = MS_SELECT;
                dim_d        = DIM_TOP;
                fade_d       = {FADE_W{1'b0}};
                hold_d       = {HOLD_W{1'b0}};
                start_pend_d = 1'b0;
                over_pend_d  = 1'b0;
            end
        endcase
    end

    // State, counters, pending flags and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MS_SELECT;
            fade_q       <= {FADE_W{1'b0}};
            hold_q       <= {HOLD_W{1'b0}};
            dim_q        <= DIM_TOP;
            start_pend_q <= 1'b0;
            over_pend_q  <= 1'b0;
            enable_q     <= MODE_SELECT;
            in_trans_q   <= 1'b0;
            dim_color_q  <= 12'h000;
        end else begin
            state_q      <= state_d;
            fade_q       <= fade_d;
            hold_q       <= hold_d;
            dim_q        <= dim_d;
            start_pend_q <= start_pend_d;
            over_pend_q  <= over_pend_d;
            enable_q     <= mode_of(state_d);
            in_trans_q   <= is_fade(state_d);
            dim_color_q  <= dim_color_s;
        end
    end

    assign enable        = enable_q;
    assign dim_level     = dim_q;
    assign in_transition = in_trans_q;
    assign dim_color     = dim_color_q;

endmodule

// File: tb/tb_mask_sequencer.sv
// Directed scoreboard bench for mask_sequencer with short fade/hold settings.
module tb_mask_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_start = 1'b0;
    logic        game_over = 1'b0;
    logic [11:0] pri_color = 12'hFA8;
    logic [1:0]  enable;
    logic [11:0] dim_color;
    logic [1:0]  dim_level;
    logic        in_transition;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] en;
        logic [1:0] lvl;
        logic       tr;
    } exp_t;

    exp_t exp_q[$];

    mask_sequencer #(
        .FADE_FRAMES   (2),
        .RESULT_FRAMES (4),
        .DIM_MAX       (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .btn_start     (btn_start),
        .game_over     (game_over),
        .pri_color     (pri_color),
        .enable        (enable),
        .dim_color     (dim_color),
        .dim_level     (dim_level),
        .in_transition (in_transition)
    );

    always #5 clk = ~clk;

    // Hand-derived dimmed values of 12'hFA8.
    function automatic logic [11:0] col_for(logic [1:0] lvl);
        case (lvl)
            2'd0:    col_for = 12'hFA8;
            2'd1:    col_for = 12'h754;
            2'd2:    col_for = 12'h322;
            default: col_for = 12'h111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        check({tag, ".enable"}, {10'd0, enable}, {10'd0, e.en});
        check({tag, ".dim_level"}, {10'd0, dim_level}, {10'd0, e.lvl});
        check({tag, ".in_transition"}, {11'd0, in_transition}, {11'd0, e.tr});
    endtask

    // Push the expectation, issue one frame_tick, then pop and compare.
    task automatic step(input string tag, input logic [1:0] en, input logic [1:0] lvl,
                        input logic tr, input logic with_start);
        exp_t e;
        exp_q.push_back('{en: en, lvl: lvl, tr: tr});
        @(negedge clk);
        frame_tick = 1'b1;
        btn_start  = with_start;
        @(negedge clk);
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            check_state(tag, e);
            @(negedge clk);
            check({tag, ".dim_color"}, dim_color, col_for(e.lvl));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
    endtask

    task automatic pulse_over();
        @(negedge clk);
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset.enable", {10'd0, enable}, 12'h001);
        check("reset.dim_level", {10'd0, dim_level}, 12'h002);
        check("reset.dim_color", dim_color, 12'h000);
        check("reset.in_transition", {11'd0, in_transition}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        step("idle0", 2'b01, 2'd2, 1'b0, 1'b0);
        step("idle1", 2'b01, 2'd2, 1'b0, 1'b0);
        step("idle2", 2'b01, 2'd2, 1'b0, 1'b0);

        pulse_start();
        repeat (3) @(negedge clk);
        check("midframe.enable", {10'd0, enable}, 12'h001);

        step("gin0", 2'b00, 2'd2, 1'b1, 1'b0);
        step("gin1", 2'b00, 2'd2, 1'b1, 1'b0);
        step("gin2", 2'b00, 2'd1, 1'b1, 1'b0);
        pulse_over();
        step("gin3", 2'b00, 2'd1, 1'b1, 1'b0);
        step("game", 2'b00, 2'd0, 1'b0, 1'b0);

        step("rin0", 2'b10, 2'd0, 1'b1, 1'b0);
        step("rin1", 2'b10, 2'd0, 1'b1, 1'b0);
        step("rin2", 2'b10, 2'd1, 1'b1, 1'b0);
        step("rin3", 2'b10, 2'd1, 1'b1, 1'b0);
        step("res_entry", 2'b10, 2'd2, 1'b0, 1'b0);

        step("hold3", 2'b10, 2'd2, 1'b0, 1'b0);
        pulse_start();
        step("hold2", 2'b10, 2'd2, 1'b0, 1'b0);
        step("hold1", 2'b10, 2'd2, 1'b0, 1'b0);
        step("hold0", 2'b10, 2'd2, 1'b0, 1'b0);
        step("back_select", 2'b01, 2'd2, 1'b0, 1'b0);
        step("select_stays", 2'b01, 2'd2, 1'b0, 1'b0);

        step("same_cycle_start", 2'b00, 2'd2, 1'b1, 1'b1);
        step("gin_again1", 2'b00, 2'd2, 1'b1, 1'b0);
        pulse_over();
        step("gin_again2", 2'b00, 2'd1, 1'b1, 1'b0);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.enable", {10'd0, enable}, 12'h001);
        check("async_rst.dim_level", {10'd0, dim_level}, 12'h002);
        check("async_rst.dim_color", dim_color, 12'h000);
        check("async_rst.in_transition", {11'd0, in_transition}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        step("post_rst0", 2'b01, 2'd2, 1'b0, 1'b0);
        step("post_rst1", 2'b01, 2'd2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
